// File: rtl/cpm_pkg.sv
// rtl/cpm_pkg.sv - shared widths, depths and request record for the CPM request queue
package cpm_pkg;

  localparam int REQ_DW   = 4;
  localparam int IDX_AW   = 2;
  localparam int ADR_AW   = 8;
  localparam int DAT_DW   = 16;
  localparam int QUE_DEP  = 4;
  localparam int WAIT_MAX = 15;
  localparam int QUE_AW   = $clog2(QUE_DEP + 1);
  localparam int WAIT_AW  = $clog2(WAIT_MAX + 1);

  typedef struct packed {
    logic [IDX_AW-1:0] idx;
    logic [ADR_AW-1:0] adr;
    logic [DAT_DW-1:0] dat;
  } cpm_req_t;

endpackage

// File: rtl/cpm_req_que_if.sv
// rtl/cpm_req_que_if.sv - requester, arbiter and crossbar side signals of the request queue
interface cpm_req_que_if;
  import cpm_pkg::*;

  logic                     flush;
  logic [REQ_DW-1:0]        IN_VLD;
  logic [REQ_DW-1:0]        IN_RDY;
  logic [REQ_DW*IDX_AW-1:0] IN_IDX;
  logic [REQ_DW*ADR_AW-1:0] IN_ADR;
  logic [REQ_DW*DAT_DW-1:0] IN_DAT;
  logic [REQ_DW-1:0]        REQ_ARB;
  logic [REQ_DW*IDX_AW-1:0] REQ_IDX;
  logic [REQ_DW-1:0]        GNT_ARB;
  logic [REQ_DW*ADR_AW-1:0] HEAD_ADR;
  logic [REQ_DW*DAT_DW-1:0] HEAD_DAT;
  logic [REQ_DW*QUE_AW-1:0] QUE_CNT;
  logic [REQ_DW-1:0]        STALL_FLG;

  modport master (
    output flush, IN_VLD, IN_IDX, IN_ADR, IN_DAT, GNT_ARB,
    input  IN_RDY, REQ_ARB, REQ_IDX, HEAD_ADR, HEAD_DAT, QUE_CNT, STALL_FLG
  );

  modport slave (
    input  flush, IN_VLD, IN_IDX, IN_ADR, IN_DAT, GNT_ARB,
    output IN_RDY, REQ_ARB, REQ_IDX, HEAD_ADR, HEAD_DAT, QUE_CNT, STALL_FLG
  );

endinterface

// File: rtl/cpm_req_fifo.sv
// rtl/cpm_req_fifo.sv - one requester FIFO with combinational head read and head wait counter
module cpm_req_fifo
  import cpm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_vld_i,
  output logic               push_rdy_o,
  input  cpm_req_t           push_req_i,
  input  logic               pop_i,
  output logic               head_vld_o,
  output cpm_req_t           head_req_o,
  output logic [QUE_AW-1:0]  cnt_o,
  output logic               stall_o
);

  localparam int PTR_AW = $clog2(QUE_DEP);

  logic [PTR_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [QUE_AW-1:0]  cnt_q, cnt_d;
  logic [WAIT_AW-1:0] wait_q, wait_d;
  cpm_req_t           mem_q [QUE_DEP];

  logic full;
  logic push;
  logic pop;

  assign full       = (cnt_q == QUE_AW'(QUE_DEP));
  assign head_vld_o = (cnt_q != '0);
  assign push_rdy_o = ~full & ~flush_i & ~rst;
  assign push       = push_vld_i & push_rdy_o;
  // A grant landing in a flush cycle is dropped together with the entries.
  assign pop        = pop_i & head_vld_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (pop || !head_vld_o)
      wait_d = '0;
    else if (wait_q != WAIT_AW'(WAIT_MAX))
      wait_d = wait_q + 1'b1;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      wait_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_req_i;
  end

  assign head_req_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
  assign cnt_o      = cnt_q;
  assign stall_o    = (wait_q == WAIT_AW'(WAIT_MAX));

endmodule

// File: rtl/cpm_req_que.sv
// rtl/cpm_req_que.sv - per-requester request queues feeding the CPM bank arbiter and crossbar
module cpm_req_que
  import cpm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cpm_req_que_if.slave bus
);

  logic [REQ_DW-1:0]        pop;
  logic [REQ_DW-1:0]        in_rdy;
  logic [REQ_DW-1:0]        req_arb;
  logic [REQ_DW-1:0]        stall_flg;
  logic [REQ_DW*IDX_AW-1:0] req_idx;
  logic [REQ_DW*ADR_AW-1:0] head_adr;
  logic [REQ_DW*DAT_DW-1:0] head_dat;
  logic [REQ_DW*QUE_AW-1:0] que_cnt;

  // Grants for empty queues are ignored here rather than trusted from the arbiter.
  assign pop = bus.GNT_ARB & req_arb;

  for (genvar p = 0; p < REQ_DW; p++) begin : g_que
    cpm_req_t in_req;
    cpm_req_t head_req;

    assign in_req = {bus.IN_IDX[p*IDX_AW +: IDX_AW],
                     bus.IN_ADR[p*ADR_AW +: ADR_AW],
                     bus.IN_DAT[p*DAT_DW +: DAT_DW]};

    cpm_req_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (bus.flush),
      .push_vld_i (bus.IN_VLD[p]),
      .push_rdy_o (in_rdy[p]),
      .push_req_i (in_req),
      .pop_i      (pop[p]),
      .head_vld_o (req_arb[p]),
      .head_req_o (head_req),
      .cnt_o      (que_cnt[p*QUE_AW +: QUE_AW]),
      .stall_o    (stall_flg[p])
    );

    assign req_idx[p*IDX_AW +: IDX_AW]  = head_req.idx;
    assign head_adr[p*ADR_AW +: ADR_AW] = head_req.adr;
    assign head_dat[p*DAT_DW +: DAT_DW] = head_req.dat;
  end

  assign bus.IN_RDY    = in_rdy;
  assign bus.REQ_ARB   = req_arb;
  assign bus.REQ_IDX   = req_idx;
  assign bus.HEAD_ADR  = head_adr;
  assign bus.HEAD_DAT  = head_dat;
  assign bus.QUE_CNT   = que_cnt;
  assign bus.STALL_FLG = stall_flg;

endmodule
